// File: rtl/div_nonrestoring.sv
// -----------------------------------------------------------------------------
// div_nonrestoring
//
// Sequential unsigned divider, 32-bit dividend by 16-bit divisor, using the
// non-restoring algorithm and producing one quotient bit per clock. A division
// takes 32 iteration cycles after the load edge. The quotient is held in
// reg_q. The remainder is corrected combinationally on the way out.
//
// Ports:
//   clk    in   1   rising-edge clock
//   clrn   in   1   asynchronous active-low reset
//   a      in  32   unsigned dividend, sampled on the load edge
//   b      in  16   unsigned divisor, sampled on the load edge
//   start  in   1   load request, level-sampled on a rising edge
//   q      out 32   quotient register
//   r      out 16   corrected remainder
//   busy   out  1   high while iterating
//   ready  out  1   one-cycle completion pulse (busy falling edge)
//   count  out  5   iteration counter, 0 while idle
//
// Build option:
//   DIV_RESTART_EN  when defined, start while busy aborts the running
//                   division and loads new operands. When undefined, start
//                   is ignored while busy.
//
// Divide by zero is not flagged. It yields q = 32'hFFFFFFFF and r = a[15:0].
// -----------------------------------------------------------------------------
module div_nonrestoring (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] a,
  input  logic [15:0] b,
  input  logic        start,
  output logic [31:0] q,
  output logic [15:0] r,
  output logic        busy,
  output logic        ready,
  output logic [4:0]  count
);

  logic [31:0] reg_q;   // dividend shifting out, quotient shifting in
  logic [15:0] reg_b;   // latched divisor
  logic [15:0] reg_r;   // partial remainder magnitude bits
  logic        r_sign;  // sign of partial remainder
  logic        busy2;   // busy delayed one cycle, for the ready pulse
  logic        load;

  logic [17:0] t;       // shifted partial remainder with next dividend bit
  logic [17:0] s;       // next partial remainder
  logic        unused_s16;

`ifdef DIV_RESTART_EN
  assign load = start;
`else
  assign load = start & ~busy;
`endif

  // The partial remainder always lies in [-b, b). Its doubled form plus one
  // bit therefore needs 18 bits. After the add or subtract it fits in
  // 17 bits again, so s[16] always equals s[17] and only s[17] is kept.
  always_comb begin
    t = {r_sign, reg_r, reg_q[31]};
    if (r_sign)
      s = t + {2'b00, reg_b};
    else
      s = t - {2'b00, reg_b};
  end

  assign unused_s16 = s[16];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      reg_q  <= '0;
      reg_b  <= '0;
      reg_r  <= '0;
      r_sign <= 1'b0;
      busy   <= 1'b0;
      busy2  <= 1'b0;
      count  <= '0;
    end else begin
      busy2 <= busy;
      if (load) begin
        reg_q  <= a;
        reg_b  <= b;
        reg_r  <= '0;
        r_sign <= 1'b0;
        count  <= '0;
        busy   <= 1'b1;
      end else if (busy) begin
        reg_r  <= s[15:0];
        r_sign <= s[17];
        reg_q  <= {reg_q[30:0], ~s[17]};
        count  <= count + 5'd1;          // wraps 31 -> 0 on the final edge
        if (count == 5'd31)
          busy <= 1'b0;
      end
    end
  end

  assign q     = reg_q;
  // A negative final partial remainder is corrected by adding the divisor back.
  assign r     = r_sign ? reg_r + reg_b : reg_r;
  // A restart keeps busy high, so an aborted division never raises ready.
  assign ready = ~busy & busy2;

endmodule

// File: tb/tb_div_nonrestoring.sv
module tb_div_nonrestoring;

  logic        clk;
  logic        clrn;
  logic [31:0] a;
  logic [15:0] b;
  logic        start;
  logic [31:0] q;
  logic [15:0] r;
  logic        busy;
  logic        ready;
  logic [4:0]  count;

  div_nonrestoring dut (
    .clk   (clk),
    .clrn  (clrn),
    .a     (a),
    .b     (b),
    .start (start),
    .q     (q),
    .r     (r),
    .busy  (busy),
    .ready (ready),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] eq;
    logic [15:0] er;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_ready_seen = 0;
  int   n_ready_exp  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (clrn && ready) begin
      n_ready_seen++;
      if (sb.size() == 0) begin
        chk("unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("q", q, e.eq);
        chk("r", {16'h0, r}, {16'h0, e.er});
      end
    end
  end

  // Called at a negedge. Returns at the negedge after the load edge.
  task automatic issue(input logic [31:0] av, input logic [15:0] bv,
                       input logic [31:0] eq, input logic [15:0] er);
    exp_t e;
    a = av;
    b = bv;
    start = 1'b1;
    e.eq = eq;
    e.er = er;
    sb.push_back(e);
    n_ready_exp++;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles from the current negedge and checks the count sequence.
  // Returns at the negedge where ready should be high.
  task automatic wait_done(input int start_count, input string name);
    int c;
    bit ok;
    c  = 0;
    ok = 1'b1;
    while (busy && c < 64) begin
      if (int'(count) != start_count + c) ok = 1'b0;
      c++;
      @(negedge clk);
    end
    chk({name, "_busy_cycles"}, c, 32 - start_count);
    chk({name, "_count_seq"}, {31'd0, ok}, 32'd1);
    chk({name, "_ready"}, {31'd0, ready}, 32'd1);
    chk({name, "_count_wrap"}, {27'd0, count}, 32'd0);
  endtask

  task automatic wait_count(input int target);
    int i;
    i = 0;
    while (!(busy && int'(count) == target) && i < 64) begin
      i++;
      @(negedge clk);
    end
    chk("reach_count", {31'd0, (i < 64)}, 32'd1);
  endtask

  typedef struct {
    logic [31:0] va;
    logic [15:0] vb;
    logic [31:0] eq;
    logic [15:0] er;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'h12345678, 16'h0000, 32'hFFFFFFFF, 16'h5678};
    vecs[1] = '{32'hFFFFFFFF, 16'hFFFF, 32'h00010001, 16'h0000};
    vecs[2] = '{32'h00000005, 16'hFFFF, 32'h00000000, 16'h0005};
    vecs[3] = '{32'h00000064, 16'h0007, 32'h0000000E, 16'h0002};
    vecs[4] = '{32'hFFFFFFFF, 16'h0001, 32'hFFFFFFFF, 16'h0000};
    vecs[5] = '{32'h80000000, 16'h0003, 32'h2AAAAAAA, 16'h0002};

    clrn  = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    @(negedge clk);
    chk("rst_q", q, 32'h0);
    chk("rst_r", {16'h0, r}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_count", {27'd0, count}, 32'd0);
    clrn = 1'b1;
    @(negedge clk);

    // First division, then back-to-back start during the ready cycle.
    issue(32'h4C7F228A, 16'h6A0E, 32'h0000B8A6, 16'h4D76);
    chk("load_busy", {31'd0, busy}, 32'd1);
    wait_done(0, "op1");
    issue(32'h00FFFF00, 16'h0004, 32'h003FFFC0, 16'h0000);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_count", {27'd0, count}, 32'd0);
    wait_done(0, "op2");
    @(negedge clk);
    chk("ready_one_cycle", {31'd0, ready}, 32'd0);
    chk("hold_q", q, 32'h003FFFC0);
    chk("hold_r", {16'h0, r}, 32'h0);

    foreach (vecs[i]) begin
      issue(vecs[i].va, vecs[i].vb, vecs[i].eq, vecs[i].er);
      wait_done(0, $sformatf("vec%0d", i));
      @(negedge clk);
    end

    // Reset in the middle of a division aborts it with no ready pulse.
    issue(32'h4C7F228A, 16'h6A0E, 32'h0000B8A6, 16'h4D76);
    wait_count(10);
    void'(sb.pop_back());
    n_ready_exp--;
    #2 clrn = 1'b0;
    #1;
    chk("abort_q", q, 32'h0);
    chk("abort_r", {16'h0, r}, 32'h0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ready", {31'd0, ready}, 32'd0);
    chk("abort_count", {27'd0, count}, 32'd0);
    @(negedge clk);
    clrn = 1'b1;
    repeat (40) @(negedge clk);

    // Start while busy: ignored, or a restart when DIV_RESTART_EN is set.
    issue(32'h00000064, 16'h0007, 32'h0000000E, 16'h0002);
    wait_count(10);
    a = 32'h80000000;
    b = 16'h0003;
    start = 1'b1;
`ifdef DIV_RESTART_EN
    begin
      exp_t e;
      void'(sb.pop_back());
      e.eq = 32'h2AAAAAAA;
      e.er = 16'h0002;
      sb.push_back(e);
    end
`endif
    @(negedge clk);
    start = 1'b0;
    a = 32'hDEADBEEF;
    b = 16'h1234;
`ifdef DIV_RESTART_EN
    wait_done(0, "restart");
`else
    wait_done(11, "ignore");
`endif
    repeat (5) @(negedge clk);

    chk("sb_empty", sb.size(), 32'd0);
    chk("ready_pulses", n_ready_seen, n_ready_exp);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
